// File: rtl/button_scan_mux_selector_pkg.sv
// Shared constants and helpers for the button-driven switch selector.
// Holds default timing constants, button slot indices and a width helper.
package button_scan_mux_selector_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_SCAN_PERIOD     = 50_000_000;

  localparam int NUM_BTNS  = 4;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  // Bits needed to count 0..n-1, never fewer than one.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/button_debounce_pulse.sv
// Synchronises and debounces one raw button; emits a one-cycle pulse on an accepted press.
// Latency: raw edge to pulse is 2 sync cycles plus DEBOUNCE_CYCLES; no flow control.
module button_debounce_pulse
  import button_scan_mux_selector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_pulse
);

  localparam int               CNT_W    = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_level;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta  <= i_raw;
      r_sync  <= r_meta;
      r_pulse <= 1'b0;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // The differing level has now held for the full window.
        r_cnt   <= '0;
        r_level <= r_sync;
        r_pulse <= r_sync;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/button_scan_mux_selector.sv
// Button-stepped N:1 switch selector with auto-scan and output hold, driving board LEDs.
// Selected bit is registered one cycle after the index; no flow control, buttons are debounced.
module button_scan_mux_selector
  import button_scan_mux_selector_pkg::*;
#(
  parameter int NUM_INPUTS      = 16,
  parameter int SEL_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SCAN_PERIOD     = DEF_SCAN_PERIOD
) (
  input  logic                  clkFromBoard,
  input  logic                  resetButtonActiveLow,
  input  logic [NUM_INPUTS-1:0] physicalSwitchInputs,
  input  logic                  upBtn,
  input  logic                  downBtn,
  input  logic                  leftBtn,
  input  logic                  rightBtn,
  output logic                  selectedBitLED,
  output logic [SEL_WIDTH-1:0]  selectIndexLEDs,
  output logic                  scanModeLED,
  output logic                  holdLED
);

  localparam int                   PAD_W     = 2 ** SEL_WIDTH;
  localparam int                   SCAN_W    = clog2(SCAN_PERIOD);
  localparam logic [SEL_WIDTH-1:0] IDX_LAST  = SEL_WIDTH'(NUM_INPUTS - 1);
  localparam logic [SCAN_W-1:0]    SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);

  logic [NUM_BTNS-1:0]   w_btn_raw;
  logic [NUM_BTNS-1:0]   w_btn_pulse;
  logic [NUM_BTNS-1:0]   w_btn_level_unused;

  logic [NUM_INPUTS-1:0] r_sw_meta;
  logic [NUM_INPUTS-1:0] r_sw_sync;
  logic [PAD_W-1:0]      w_sw_pad;

  logic [SEL_WIDTH-1:0]  r_index;
  logic [SCAN_W-1:0]     r_scan_cnt;
  logic                  r_scan;
  logic                  r_hold;
  logic                  r_sel;

  logic                  w_up;
  logic                  w_down;
  logic                  w_left;
  logic                  w_right;
  logic                  w_tick;
  logic                  w_hold_next;
  logic [SEL_WIDTH-1:0]  w_idx_inc;
  logic [SEL_WIDTH-1:0]  w_idx_dec;
  logic [SEL_WIDTH-1:0]  w_index_next;
  logic [SCAN_W-1:0]     w_scan_cnt_next;

  assign w_btn_raw[BTN_UP]    = upBtn;
  assign w_btn_raw[BTN_DOWN]  = downBtn;
  assign w_btn_raw[BTN_LEFT]  = leftBtn;
  assign w_btn_raw[BTN_RIGHT] = rightBtn;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    button_debounce_pulse #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk  (clkFromBoard),
      .i_rst_n(resetButtonActiveLow),
      .i_raw  (w_btn_raw[g]),
      .o_level(w_btn_level_unused[g]),
      .o_pulse(w_btn_pulse[g])
    );
  end

  assign w_up    = w_btn_pulse[BTN_UP];
  assign w_down  = w_btn_pulse[BTN_DOWN];
  assign w_left  = w_btn_pulse[BTN_LEFT];
  assign w_right = w_btn_pulse[BTN_RIGHT];

  // Zero-extend so any index value addresses a real bit.
  assign w_sw_pad    = PAD_W'(r_sw_sync);
  assign w_tick      = r_scan && (r_scan_cnt == SCAN_LAST);
  assign w_hold_next = r_hold ^ w_right;

  always_comb begin
    w_idx_inc    = (r_index == IDX_LAST) ? '0 : r_index + SEL_WIDTH'(1);
    w_idx_dec    = (r_index == '0) ? IDX_LAST : r_index - SEL_WIDTH'(1);
    w_index_next = r_index;
    if (w_up && w_down) begin
      w_index_next = r_index;
    end else if (w_up) begin
      w_index_next = w_idx_inc;
    end else if (w_down) begin
      w_index_next = w_idx_dec;
    end else if (w_tick) begin
      w_index_next = w_idx_inc;
    end
  end

  // Manual steps and mode toggles restart the scan period.
  always_comb begin
    w_scan_cnt_next = r_scan_cnt + SCAN_W'(1);
    if (w_left || !r_scan || w_up || w_down || w_tick) begin
      w_scan_cnt_next = '0;
    end
  end

  always_ff @(posedge clkFromBoard) begin
    if (!resetButtonActiveLow) begin
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_index    <= '0;
      r_scan_cnt <= '0;
      r_scan     <= 1'b0;
      r_hold     <= 1'b0;
      r_sel      <= 1'b0;
    end else begin
      r_sw_meta  <= physicalSwitchInputs;
      r_sw_sync  <= r_sw_meta;
      r_index    <= w_index_next;
      r_scan_cnt <= w_scan_cnt_next;
      r_scan     <= r_scan ^ w_left;
      r_hold     <= w_hold_next;
      if (!w_hold_next) begin
        r_sel <= w_sw_pad[r_index];
      end
    end
  end

  assign selectedBitLED  = r_sel;
  assign selectIndexLEDs = r_index;
  assign scanModeLED     = r_scan;
  assign holdLED         = r_hold;

endmodule

// File: tb/tb_button_scan_mux_selector.sv
// Randomised and directed bench for button_scan_mux_selector with a window-based reference model.
module tb_button_scan_mux_selector;

  localparam int N  = 10;
  localparam int SW = 4;
  localparam int D  = 4;
  localparam int P  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  sw = '0;
  logic          up = 1'b0;
  logic          dn = 1'b0;
  logic          lf = 1'b0;
  logic          rt = 1'b0;
  logic          sel;
  logic [SW-1:0] idx;
  logic          scan;
  logic          hold;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic          sel;
    logic [SW-1:0] idx;
    logic          scan;
    logic          hold;
  } exp_t;

  exp_t         expq[$];
  logic [3:0]   bq[$];
  logic [N-1:0] swq[$];

  int         m_idx;
  int         m_age;
  bit         m_scan;
  bit         m_hold;
  bit         m_sel;
  logic [3:0] m_lvl;
  logic [3:0] m_pend;

  always #5 clk = ~clk;

  button_scan_mux_selector #(
    .NUM_INPUTS(N), .SEL_WIDTH(SW), .DEBOUNCE_CYCLES(D), .SCAN_PERIOD(P)
  ) dut (
    .clkFromBoard        (clk),
    .resetButtonActiveLow(rst_n),
    .physicalSwitchInputs(sw),
    .upBtn               (up),
    .downBtn             (dn),
    .leftBtn             (lf),
    .rightBtn            (rt),
    .selectedBitLED      (sel),
    .selectIndexLEDs     (idx),
    .scanModeLED         (scan),
    .holdLED             (hold)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state after each clock edge, from the rules rather than the register structure.
  // A button level is accepted when its last D synchronised samples all differ from it.
  task automatic model_step();
    logic [3:0]   raw;
    logic [N-1:0] swv;
    bit           u, d, l, r, tick, diff;
    int           old_idx;
    exp_t         e;
    raw = {rt, lf, dn, up};
    if (!rst_n) begin
      m_idx = 0; m_age = 0; m_scan = 0; m_hold = 0; m_sel = 0;
      m_lvl = '0; m_pend = '0;
      bq.delete(); swq.delete();
      for (int i = 0; i < D + 2; i++) bq.push_back(4'b0);
      for (int i = 0; i < 3; i++) swq.push_back('0);
    end else begin
      swq.push_back(sw);
      void'(swq.pop_front());
      swv = swq[0];
      bq.push_back(raw);
      void'(bq.pop_front());
      u = m_pend[0]; d = m_pend[1]; l = m_pend[2]; r = m_pend[3];
      tick = m_scan && (m_age == P - 1);
      old_idx = m_idx;
      if (u && d) m_idx = m_idx;
      else if (u) m_idx = (m_idx + 1) % N;
      else if (d) m_idx = (m_idx + N - 1) % N;
      else if (tick) m_idx = (m_idx + 1) % N;
      if (l) begin
        m_scan = !m_scan;
        m_age = 0;
      end else if (!m_scan || u || d || tick) begin
        m_age = 0;
      end else begin
        m_age = m_age + 1;
      end
      m_hold = m_hold ^ r;
      if (!m_hold) m_sel = swv[old_idx];
      m_pend = '0;
      for (int b = 0; b < 4; b++) begin
        diff = 1;
        for (int k = 0; k < D; k++) if (bq[k][b] == m_lvl[b]) diff = 0;
        if (diff) begin
          m_lvl[b] = ~m_lvl[b];
          m_pend[b] = m_lvl[b];
        end
      end
    end
    e.sel = m_sel; e.idx = SW'(m_idx); e.scan = m_scan; e.hold = m_hold;
    expq.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (expq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_empty: got no expectation for cycle at %0t", $time);
    end else begin
      e = expq.pop_front();
      check("sb_sel", 32'(sel), 32'(e.sel));
      check("sb_idx", 32'(idx), 32'(e.idx));
      check("sb_scan", 32'(scan), 32'(e.scan));
      check("sb_hold", 32'(hold), 32'(e.hold));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: up = v;
      1: dn = v;
      2: lf = v;
      default: rt = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    cyc(D + 3);
    set_btn(b, 1'b0);
    cyc(D + 4);
  endtask

  int         hold_left[4];
  int         guard;

  initial begin
    // 1: reset and first selection
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    check("rst_sel", 32'(sel), 0);
    check("rst_idx", 32'(idx), 0);
    check("rst_scan", 32'(scan), 0);
    check("rst_hold", 32'(hold), 0);
    sw = '1;
    cyc(4);
    check("sw_all_ones_sel", 32'(sel), 1);

    // 2: glitch rejection, exact latency, wrap
    up = 1'b1; cyc(2); up = 1'b0; cyc(12);
    check("glitch_no_step", 32'(idx), 0);
    up = 1'b1;
    cyc(6);
    check("latency_before", 32'(idx), 0);
    cyc(1);
    check("latency_at7", 32'(idx), 1);
    cyc(3);
    up = 1'b0;
    cyc(D + 4);
    check("single_step", 32'(idx), 1);
    repeat (9) press(0);
    check("wrap_9_to_0", 32'(idx), 0);

    // 3: down wrap and simultaneous up/down
    press(1);
    check("down_wrap", 32'(idx), 9);
    up = 1'b1; dn = 1'b1;
    cyc(D + 3);
    up = 1'b0; dn = 1'b0;
    cyc(D + 4);
    check("up_down_cancel", 32'(idx), 9);

    // 4: auto-scan with a manual step mid-period
    press(2);
    check("scan_on", 32'(scan), 1);
    cyc(21);
    press(0);
    cyc(30);
    press(2);
    check("scan_off", 32'(scan), 0);

    // 5: hold freezes the selected bit
    sw = 10'b00_0000_0100;
    guard = 0;
    while (m_idx != 2 && guard < 12) begin
      press(0);
      guard++;
    end
    check("steer_idx2", 32'(idx), 2);
    cyc(3);
    check("live_sel_idx2", 32'(sel), 1);
    press(3);
    check("hold_on", 32'(hold), 1);
    sw = '0;
    press(0);
    check("held_sel", 32'(sel), 1);
    check("held_idx_tracks", 32'(idx), 3);
    press(3);
    check("hold_off", 32'(hold), 0);
    check("released_sel", 32'(sel), 0);

    // 6: reset mid-scan, held, mid-debounce
    press(2);
    press(3);
    up = 1'b1;
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    check("midrst_sel", 32'(sel), 0);
    check("midrst_idx", 32'(idx), 0);
    check("midrst_scan", 32'(scan), 0);
    check("midrst_hold", 32'(hold), 0);
    up = 1'b0;
    rst_n = 1'b1;
    cyc(20);
    check("no_spurious_idx", 32'(idx), 0);

    // Random phase
    for (int b = 0; b < 4; b++) hold_left[b] = 0;
    for (int t = 0; t < 800; t++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold_left[b] == 0) begin
          set_btn(b, ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0);
          hold_left[b] = $urandom_range(1, 10);
        end else begin
          hold_left[b]--;
        end
      end
      if ($urandom_range(0, 15) == 0) sw = N'($urandom);
      rst_n = (t == 400) ? 1'b0 : 1'b1;
      cyc(1);
    end
    up = 1'b0; dn = 1'b0; lf = 1'b0; rt = 1'b0;
    rst_n = 1'b1;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
